mul_sign: RTL and testbench
===========================

# mul_sign

Sequential signed fixed-point multiplier for the ALU datapath, the multiplicative counterpart of the signed divider in the same ALU. It accepts two's-complement Q-format operands and converts them to magnitude form. It runs an iterative unsigned shift-add core, then restores the sign. Results come back through the same start/complete handshake as the divider, so the two blocks can be arbitrated by one ALU sequencer.

## Interface
- Q, 15, number of fractional bits in operands and result
- N, 32, total word width including sign bit (N > Q+1)
- i_clk  input  1  clock, all logic rising-edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  start request, sampled only when o_busy=0
- i_multiplicand_sign  input  N  two's-complement Q-format operand A
- i_multiplier_sign  input  N  two's-complement Q-format operand B
- o_busy  output  1  high while an operation is in flight
- o_complete  output  1  one-cycle pulse, result valid
- o_product_sign  output  N  two's-complement Q-format product
- o_overflow  output  1  product not representable in N bits, valid with o_complete and held

## Operation
- Magnitudes are computed N bits wide, so -2^(N-1) is handled exactly with no truncation. The result sign is the XOR of the operand MSBs.
- Core: accumulator 2N bits. N iterations, one per cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift.
- Result magnitude is the accumulator right-shifted by Q, i.e. truncation toward zero.
- Overflow when magnitude > 2^(N-1)-1 (positive) or > 2^(N-1) (negative).
- A zero magnitude always yields 0 with sign bit 0; there is no negative zero.
- FSM states:
  - IDLE: on i_start, latch magnitudes and sign, clear accumulator, load counter=N, go to CALC.
  - CALC: iterate and decrement the counter; at counter=1, go to DONE.
  - DONE: register o_product_sign and o_overflow, pulse o_complete, go to IDLE.
- i_start while o_busy=1 is ignored; operands are not re-sampled.
- Outputs hold the last result until the next DONE.

## Timing
- Reset values: o_busy=0, o_complete=0, o_product_sign=0, o_overflow=0, FSM=IDLE, counter=0.
- Start sampled at edge 0; o_busy=1 from edge 0.
- CALC covers edges 1..N; DONE state is entered at edge N.
- At edge N+1, o_complete=1 for exactly one cycle, outputs update and o_busy=0.
- Latency is N+1 cycles from the start edge to the complete edge.
- Back-to-back: i_start asserted in the o_complete cycle is accepted, giving a throughput of one result per N+1 cycles.
- i_rst asserted mid-operation aborts at the next edge: IDLE, all outputs 0, no o_complete.
- i_rst has priority over i_start in the same cycle.

## Configuration
- MUL_SIGN_SAT_EN defined: on overflow, o_product_sign saturates to 2^(N-1)-1 (positive) or -2^(N-1) (negative), and o_overflow=1.
- Undefined: on overflow, o_product_sign is the low N bits of the signed shifted product (wrap-around), and o_overflow=1.
- o_overflow behaviour is identical in both builds.

## Structure
- Package mul_sign_pkg holds:
  - the FSM state enum (IDLE, CALC, DONE);
  - a function producing the N-bit magnitude of a two's-complement word;
  - the counter-width constant $clog2(N+1).
- Sub-module qmul_core: unsigned iterative shift-add core with the accumulator, counter and its own start/done. It mirrors the unsigned divider core.
- mul_sign holds sign handling, overflow/saturation and the handshake FSM.

## Test plan
- Positive times negative: N=32, Q=15, A=0x0000C000 (1.5), B=0xFFFF0000 (-2.0). Expect o_product_sign=0xFFFE8000, o_overflow=0, and o_complete exactly 33 cycles after start.
- Positive overflow: A=B=0x00800000 (256.0). With MUL_SIGN_SAT_EN, expect 0x7FFFFFFF and o_overflow=1. Without it, expect 0x80000000 and o_overflow=1.
- Exact negative limit: A=0xFF800000 (-256.0), B=0x00800000. Expect 0x80000000 and o_overflow=0 in both builds.
- Truncation to zero: A=0xFFFFFFFF (-2^-15), B=0x00004000 (0.5). Expect 0x00000000 with sign bit clear and o_overflow=0.
- Handshake: pulse i_start again while o_busy=1, with different operands. Expect one o_complete carrying the first result. Then assert i_start in the o_complete cycle and expect a second o_complete 33 cycles later.
- Reset mid-operation: assert i_rst at cycle 10 of CALC. Expect all outputs 0 next cycle, no o_complete, and a following start that completes normally.

Source files
------------

// File: rtl/mul_sign_pkg.sv
// Shared types and constants for the signed Q-format multiplier.
// Word width, fraction width, FSM encoding and the magnitude helper live here.
package mul_sign_pkg;

    localparam int N     = 32;
    localparam int Q     = 15;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // N-bit magnitude; the most negative word maps to 2^(N-1) without loss.
    function automatic logic [N-1:0] mag_of(input logic [N-1:0] word);
        return word[N-1] ? (~word + N'(1)) : word;
    endfunction

endpackage

// File: rtl/mul_sign_if.sv
// Start/complete handshake and operand/result bus of the signed multiplier.
// The master side is the ALU sequencer, the slave side is mul_sign.
interface mul_sign_if;

    logic                       i_start;
    logic [mul_sign_pkg::N-1:0] i_multiplicand_sign;
    logic [mul_sign_pkg::N-1:0] i_multiplier_sign;
    logic                       o_busy;
    logic                       o_complete;
    logic [mul_sign_pkg::N-1:0] o_product_sign;
    logic                       o_overflow;

    modport master (
        output i_start, i_multiplicand_sign, i_multiplier_sign,
        input  o_busy, o_complete, o_product_sign, o_overflow
    );

    modport slave (
        input  i_start, i_multiplicand_sign, i_multiplier_sign,
        output o_busy, o_complete, o_product_sign, o_overflow
    );

endinterface

// File: rtl/mul_sign_qmul_core.sv
// Unsigned iterative shift-add multiplier core, one partial product per cycle.
// done is high during the final iteration, so product is complete one cycle later.
module qmul_core
    import mul_sign_pkg::*;
(
    input  logic           clk,
    input  logic           srst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           done,
    output logic [2*N-1:0] product
);

    logic [2*N-1:0]   acc_reg, acc_next;
    logic [N-1:0]     mcand_reg;
    logic [N-1:0]     mplr_reg, mplr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [N:0]       upper_sum;

    always_comb begin
        // The carry out of the upper half becomes the new MSB after the shift.
        upper_sum  = {1'b0, acc_reg[2*N-1:N]} + (mplr_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_next   = acc_reg;
        mplr_next  = mplr_reg;
        count_next = count_reg;
        if (start) begin
            acc_next   = '0;
            mplr_next  = multiplier;
            count_next = CNT_W'(N);
        end else if (count_reg != '0) begin
            acc_next   = {upper_sum, acc_reg[N-1:1]};
            mplr_next  = mplr_reg >> 1;
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg   <= '0;
            mcand_reg <= '0;
            mplr_reg  <= '0;
            count_reg <= '0;
        end else begin
            acc_reg   <= acc_next;
            mplr_reg  <= mplr_next;
            count_reg <= count_next;
            if (start) begin
                mcand_reg <= multiplicand;
            end
        end
    end

    assign done    = (count_reg == CNT_W'(1));
    assign product = acc_reg;

endmodule

// File: rtl/mul_sign.sv
// Signed Q-format sequential multiplier: sign/magnitude wrapper around qmul_core.
// Define MUL_SIGN_SAT_EN to saturate overflowing products instead of wrapping.
module mul_sign
    import mul_sign_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    mul_sign_if.slave   bus
);

    localparam int MW = 2 * N - Q;
    localparam logic [MW-1:0] POS_LIM = {{(N - Q){1'b0}}, 1'b0, {(N - 1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = {{(N - Q){1'b0}}, 1'b1, {(N - 1){1'b0}}};

    state_t         state_reg, state_next;
    logic           core_start, core_done, load_result, busy;
    logic [2*N-1:0] core_product;
    logic [MW-1:0]  mag;
    logic [N-1:0]   mag_lo, wrap_val, result_calc;
    logic           is_neg, overflow_calc;
    logic           unused_frac;
    logic           sign_reg;
    logic [N-1:0]   product_reg;
    logic           overflow_reg, complete_reg;

    qmul_core u_core (
        .clk          (i_clk),
        .srst         (i_rst),
        .start        (core_start),
        .multiplicand (mag_of(bus.i_multiplicand_sign)),
        .multiplier   (mag_of(bus.i_multiplier_sign)),
        .done         (core_done),
        .product      (core_product)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.i_start) state_next = CALC;
            CALC:    if (core_done)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_start  = (state_reg == IDLE) && bus.i_start;
        load_result = (state_reg == DONE);
        busy        = (state_reg != IDLE);
    end

    // Dropping the fraction bits of the magnitude truncates toward zero.
    assign mag         = core_product[2*N-1:Q];
    assign unused_frac = ^core_product[Q-1:0];
    assign mag_lo      = mag[N-1:0];
    assign is_neg      = sign_reg && (mag != '0);
    assign overflow_calc = is_neg ? (mag > NEG_LIM) : (mag > POS_LIM);
    assign wrap_val    = is_neg ? (~mag_lo + N'(1)) : mag_lo;

`ifdef MUL_SIGN_SAT_EN
    assign result_calc = !overflow_calc ? wrap_val :
                         (is_neg ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}});
`else
    assign result_calc = wrap_val;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sign_reg     <= 1'b0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
            complete_reg <= 1'b0;
        end else begin
            complete_reg <= load_result;
            if (core_start) begin
                sign_reg <= bus.i_multiplicand_sign[N-1] ^ bus.i_multiplier_sign[N-1];
            end
            if (load_result) begin
                product_reg  <= result_calc;
                overflow_reg <= overflow_calc;
            end
        end
    end

    assign bus.o_busy         = busy;
    assign bus.o_complete     = complete_reg;
    assign bus.o_product_sign = product_reg;
    assign bus.o_overflow     = overflow_reg;

endmodule

// File: tb/tb_mul_sign.sv
// Self-checking bench for mul_sign: directed corner cases, handshake and reset
// behaviour, then random operands against a 64-bit arithmetic reference model.
module tb_mul_sign;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [31:0] exp_p;
    logic        exp_ov;

    mul_sign_if bus ();

    mul_sign dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, magnitude truncated by 2^15, then range rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic ov);
        longint sa, sb, full, m;
        bit     neg;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        full = sa * sb;
        neg  = (full < 0);
        m    = (neg ? -full : full) / 32768;
        if (m == 0) neg = 0;
        ov = neg ? (m > (longint'(1) <<< 31)) : (m > ((longint'(1) <<< 31) - 1));
`ifdef MUL_SIGN_SAT_EN
        if (ov) p = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else    p = neg ? 32'(-m) : 32'(m);
`else
        p = neg ? 32'(-m) : 32'(m);
`endif
    endfunction

    // Called #1 after a rising edge (or before the first one); returns #1 after the start edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        model(a, b, exp_p, exp_ov);
        bus.i_start             = 1'b1;
        bus.i_multiplicand_sign = a;
        bus.i_multiplier_sign   = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check("busy_after_start", 64'(bus.o_busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input bit probe);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (probe && cyc == 5) begin
                bus.i_start             = 1'b1;
                bus.i_multiplicand_sign = bus.i_multiplicand_sign ^ 32'h1234_5678;
                bus.i_multiplier_sign   = bus.i_multiplier_sign + 32'h0001_0000;
            end
            if (probe && cyc == 6) bus.i_start = 1'b0;
            if (bus.o_complete) seen = 1;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_product"}, 64'(bus.o_product_sign), 64'(exp_p));
        check({tag, "_overflow"}, 64'(bus.o_overflow), 64'(exp_ov));
        check({tag, "_busy_clear"}, 64'(bus.o_busy), 64'd0);
        $display("op %s: product=%08h overflow=%0d latency=%0d", tag, bus.o_product_sign,
                 bus.o_overflow, cyc);
    endtask

    task automatic step_and_check_hold(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_single_pulse"}, 64'(bus.o_complete), 64'd0);
        check({tag, "_hold"}, 64'(bus.o_product_sign), 64'(exp_p));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        case ($urandom_range(0, 3))
            0: x = $urandom;
            1: x = $urandom >> $urandom_range(8, 24);
            2: begin
                case ($urandom_range(0, 3))
                    0: x = 32'h8000_0000;
                    1: x = 32'h7FFF_FFFF;
                    2: x = 32'h0000_0000;
                    default: x = 32'hFFFF_FFFF;
                endcase
            end
            default: x = 32'h0080_0000 + ($urandom >> 18) - 32'h0000_2000;
        endcase
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    initial begin
        int pulses;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_multiplicand_sign = '0;
        bus.i_multiplier_sign   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_complete", 64'(bus.o_complete), 64'd0);
        check("reset_product", 64'(bus.o_product_sign), 64'd0);
        check("reset_overflow", 64'(bus.o_overflow), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h0000_C000, 32'hFFFF_0000);
        wait_done("pos_x_neg", 0);
        check("pos_x_neg_value", 64'(bus.o_product_sign), 64'hFFFE_8000);
        step_and_check_hold("pos_x_neg");

        issue(32'h0080_0000, 32'h0080_0000);
        wait_done("pos_overflow", 0);
        step_and_check_hold("pos_overflow");

        issue(32'hFF80_0000, 32'h0080_0000);
        wait_done("neg_limit", 0);
        check("neg_limit_value", 64'(bus.o_product_sign), 64'h8000_0000);
        step_and_check_hold("neg_limit");

        issue(32'hFFFF_FFFF, 32'h0000_4000);
        wait_done("trunc_zero", 0);
        check("trunc_zero_value", 64'(bus.o_product_sign), 64'h0);

        // Start while busy is ignored; start in the complete cycle is accepted.
        issue(32'h0001_8000, 32'hFFFD_0000);
        wait_done("busy_ignore", 1);
        issue(32'h0003_0000, 32'h0002_8000);
        wait_done("back_to_back", 0);
        step_and_check_hold("back_to_back");

        // Abort after the tenth CALC cycle.
        issue(32'h0123_4567, 32'h0000_8000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_complete", 64'(bus.o_complete), 64'd0);
        check("abort_product", 64'(bus.o_product_sign), 64'd0);
        check("abort_overflow", 64'(bus.o_overflow), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_complete) pulses++;
        end
        check("abort_no_complete", 64'(pulses), 64'd0);
        issue(32'hFFFE_0000, 32'hFFFF_4000);
        wait_done("after_abort", 0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            issue(a, b);
            wait_done($sformatf("rand%0d", i), 0);
            if (i % 5 == 0) step_and_check_hold($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
